gin_id_programmer: RTL

- Sequencer that programs the ID registers of a row or column of GIN multicast controllers after configuration.
- Accepts a stream of ID values over a valid/ready config port.
- Drives one-cycle set_id strobes, one target at a time in index order, on a shared id bus.
- Sits between the top-level config path and the GIN bus instances; signals completion so the tag/data phase can begin.

---
 rtl/gin_id_programmer.sv | 100 ++++++++++
 1 files changed

// File: rtl/gin_id_programmer.sv
// Programs the ID registers of one row/column of GIN multicast controllers:
// consumes an ID stream and strobes each target in index order on a shared bus.
`ifndef XID_BITS
`define XID_BITS 8
`endif

module gin_id_strobe_cell (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  output logic q
);
  always_ff @(posedge clk) begin
    if (!rst) q <= 1'b0;
    else      q <= hit;
  end
endmodule

module gin_id_programmer #(
  parameter int ID_SIZE     = `XID_BITS,
  parameter int NUM_TARGETS = 12,
  localparam int CNT_BITS   = $clog2(NUM_TARGETS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_valid,
  input  logic [ID_SIZE-1:0]     cfg_data,
  output logic                   cfg_ready,
  output logic [NUM_TARGETS-1:0] set_id,
  output logic [ID_SIZE-1:0]     id_out,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_BITS:0]      prog_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(NUM_TARGETS - 1);
  localparam logic [CNT_BITS:0]   PMAX = (CNT_BITS+1)'(NUM_TARGETS);

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] cnt;
  logic                hs, fire, go;

  assign cfg_ready = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign hs        = cfg_valid && cfg_ready;
  // abort discards a coincident handshake
  assign fire      = hs && !abort;
  assign go        = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (abort)                     state_nxt = IDLE;
        else if (hs && cnt == LAST)    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      id_out     <= '0;
      prog_count <= '0;
    end else begin
      if (go) begin
        cnt        <= '0;
        prog_count <= '0;
      end else if (state == LOAD && abort) begin
        cnt <= '0;
      end else if (fire) begin
        id_out <= cfg_data;
        if (prog_count < PMAX) prog_count <= prog_count + 1'b1;
        if (cnt != LAST)       cnt <= cnt + 1'b1;
      end
    end
  end

  // one registered strobe cell per target; hits are mutually exclusive on cnt
  for (genvar k = 0; k < NUM_TARGETS; k++) begin : g_tgt
    gin_id_strobe_cell u_cell (
      .clk (clk),
      .rst (rst),
      .hit (fire && (cnt == CNT_BITS'(k))),
      .q   (set_id[k])
    );
  end
endmodule
